// File: rtl/sprites_wide_pkg.sv
// Shared register map and fetch-width decode for the wide sprite serializer.
package sprites_wide_pkg;

  typedef enum logic [1:0] {
    REG_POS  = 2'd0,
    REG_CTL  = 2'd1,
    REG_DATA = 2'd2,
    REG_DATB = 2'd3
  } spr_reg_e;

  localparam logic [8:0] SPR_BASE    = 9'h140;
  localparam logic [2:0] SPR_BASE_HI = SPR_BASE[8:6];

  // 00=16, 01/10=32, 11=64 pixels, never wider than the fetch path.
  function automatic logic [6:0] spr_w_decode(input logic [1:0] sw, input int fetch_w);
    logic [6:0] w;
    case (sw)
      2'b00:   w = 7'd16;
      2'b11:   w = 7'd64;
      default: w = 7'd32;
    endcase
    if (int'(w) > fetch_w) w = 7'(fetch_w);
    return w;
  endfunction

endpackage

// File: rtl/sprites_wide_if.sv
// Chip-bus register port, beam/pixel controls and mixer outputs of the sprite block.
interface sprites_wide_if #(
  parameter int NSPR    = 8,
  parameter int FETCH_W = 64,
  parameter int HPOS_W  = 11
) ();

  logic               shift_en;
  logic [8:1]         reg_address_in;
  logic [15:0]        data_in;
  logic [FETCH_W-1:0] wdata_in;
  logic [HPOS_W-1:0]  hpos;
  logic [1:0]         spr_width;
  logic               sprena;
  logic [NSPR-1:0]    nsprite;
  logic [3:0]         sprdata;

  modport master (
    output shift_en, reg_address_in, data_in, wdata_in, hpos, spr_width, sprena,
    input  nsprite, sprdata
  );

  modport slave (
    input  shift_en, reg_address_in, data_in, wdata_in, hpos, spr_width, sprena,
    output nsprite, sprdata
  );

endinterface

// File: rtl/sprite_channel.sv
// One sprite channel: position/control/data latches, arm flag, 2-stage load pipe, shifters.
// First pixel appears two enabled ticks after the hstart match; shift_en low freezes everything but register writes.
module sprite_channel
  import sprites_wide_pkg::*;
#(
  parameter int FETCH_W = 64,
  parameter int HPOS_W  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               wr_pos,
  input  logic               wr_ctl,
  input  logic               wr_data,
  input  logic               wr_datb,
  input  logic [15:0]        data_in,
  input  logic [FETCH_W-1:0] wdata_in,
  input  logic [HPOS_W-1:0]  hpos,
  input  logic [1:0]         spr_width,
  output logic [1:0]         pix,
  output logic               attach
);

  localparam int LO_W = HPOS_W - 8;

  logic [7:0]         hstart_hi_q, hstart_hi_d;
  logic [LO_W-1:0]    hstart_lo_q, hstart_lo_d;
  logic               attach_q, attach_d;
  logic               armed_q, armed_d;
  logic               load_q, load_d;
  logic               load_del_q, load_del_d;
  logic [FETCH_W-1:0] datla_q, datla_d;
  logic [FETCH_W-1:0] datlb_q, datlb_d;
  logic [FETCH_W-1:0] shifta_q, shifta_d;
  logic [FETCH_W-1:0] shiftb_q, shiftb_d;

  logic [LO_W-1:0]    ctl_lo;
  logic [6:0]         align_sh;
  logic               unused_dat;

  // Low hstart bits live in CTL in coarse-to-fine order: bit0, then bit4, then bit3.
  generate
    if (HPOS_W == 9) begin : g_lo9
      assign ctl_lo = data_in[0];
    end else if (HPOS_W == 10) begin : g_lo10
      assign ctl_lo = {data_in[0], data_in[4]};
    end else begin : g_lo11
      assign ctl_lo = {data_in[0], data_in[4], data_in[3]};
    end
  endgenerate

  assign unused_dat = ^data_in;
  assign align_sh   = 7'(FETCH_W) - spr_w_decode(spr_width, FETCH_W);

  always_comb begin
    hstart_hi_d = hstart_hi_q;
    hstart_lo_d = hstart_lo_q;
    attach_d    = attach_q;
    armed_d     = armed_q;
    load_d      = load_q;
    load_del_d  = load_del_q;
    datla_d     = datla_q;
    datlb_d     = datlb_q;
    shifta_d    = shifta_q;
    shiftb_d    = shiftb_q;

    if (wr_pos) hstart_hi_d = data_in[7:0];
    if (wr_ctl) begin
      hstart_lo_d = ctl_lo;
      attach_d    = data_in[7];
      armed_d     = 1'b0;
    end
    if (wr_data) begin
      datla_d = wdata_in;
      armed_d = 1'b1;
    end
    if (wr_datb) datlb_d = wdata_in;

    // Compare and load use the pre-write armed/data values of this cycle.
    if (shift_en) begin
      load_d     = armed_q && (hpos == {hstart_hi_q, hstart_lo_q});
      load_del_d = load_q;
      if (load_del_q) begin
        shifta_d = datla_q << align_sh;
        shiftb_d = datlb_q << align_sh;
      end else begin
        shifta_d = shifta_q << 1;
        shiftb_d = shiftb_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hstart_hi_q <= '0;
      hstart_lo_q <= '0;
      attach_q    <= 1'b0;
      armed_q     <= 1'b0;
      load_q      <= 1'b0;
      load_del_q  <= 1'b0;
      datla_q     <= '0;
      datlb_q     <= '0;
      shifta_q    <= '0;
      shiftb_q    <= '0;
    end else begin
      hstart_hi_q <= hstart_hi_d;
      hstart_lo_q <= hstart_lo_d;
      attach_q    <= attach_d;
      armed_q     <= armed_d;
      load_q      <= load_d;
      load_del_q  <= load_del_d;
      datla_q     <= datla_d;
      datlb_q     <= datlb_d;
      shifta_q    <= shifta_d;
      shiftb_q    <= shiftb_d;
    end
  end

  assign pix    = {shiftb_q[FETCH_W-1], shifta_q[FETCH_W-1]};
  assign attach = attach_q;

endmodule

// File: rtl/sprites_wide.sv
// Sprite block top: register decode, NSPR channels, per-channel valid flags and pair priority mux.
// Outputs are combinational from channel shifters, so they go transparent the cycle after reset.
module sprites_wide
  import sprites_wide_pkg::*;
#(
  parameter int NSPR    = 8,
  parameter int FETCH_W = 64,
  parameter int HPOS_W  = 11
) (
  input logic           clk,
  input logic           reset,
  sprites_wide_if.slave bus
);

  logic            hit;
  logic [2:0]      chan;
  spr_reg_e        rsel;
  logic [1:0]      pix [NSPR];
  logic [NSPR-1:0] attach;
  logic [NSPR-1:0] nsprite;
  logic [3:0]      sprdata_c;
  logic            unused_attach;

  assign hit  = (bus.reg_address_in[8:6] == SPR_BASE_HI);
  assign chan = bus.reg_address_in[5:3];
  assign rsel = spr_reg_e'(bus.reg_address_in[2:1]);

  generate
    for (genvar gi = 0; gi < NSPR; gi++) begin : g_chan
      logic sel;
      assign sel = hit && (chan == 3'(gi));

      sprite_channel #(
        .FETCH_W (FETCH_W),
        .HPOS_W  (HPOS_W)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (bus.shift_en),
        .wr_pos    (sel && (rsel == REG_POS)),
        .wr_ctl    (sel && (rsel == REG_CTL)),
        .wr_data   (sel && (rsel == REG_DATA)),
        .wr_datb   (sel && (rsel == REG_DATB)),
        .data_in   (bus.data_in),
        .wdata_in  (bus.wdata_in),
        .hpos      (bus.hpos),
        .spr_width (bus.spr_width),
        .pix       (pix[gi]),
        .attach    (attach[gi])
      );

      assign nsprite[gi] = bus.sprena && (pix[gi] != 2'b00);
    end
  endgenerate

  // Only odd channels carry a meaningful attach bit.
  assign unused_attach = ^attach;

  // Walk pairs from highest to lowest so the lowest active pair wins.
  always_comb begin
    sprdata_c = 4'd0;
    for (int p = NSPR/2 - 1; p >= 0; p--) begin
      if (nsprite[2*p] || nsprite[2*p+1]) begin
        if (attach[2*p+1])
          sprdata_c = {pix[2*p+1], pix[2*p]};
        else if (nsprite[2*p])
          sprdata_c = {2'(p), pix[2*p]};
        else
          sprdata_c = {2'(p), pix[2*p+1]};
      end
    end
  end

  assign bus.nsprite = nsprite;
  assign bus.sprdata = sprdata_c;

endmodule

// File: tb/tb_sprites_wide.sv
// Directed bench for sprites_wide: expected {nsprite,sprdata} per cycle queued ahead, then compared.
module tb_sprites_wide;

  localparam int NSPR    = 8;
  localparam int FETCH_W = 64;
  localparam int HPOS_W  = 11;
  localparam logic [10:0] H_IDLE = 11'h7FF;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [11:0] exp_q [$];

  sprites_wide_if #(.NSPR(NSPR), .FETCH_W(FETCH_W), .HPOS_W(HPOS_W)) bus ();

  sprites_wide #(.NSPR(NSPR), .FETCH_W(FETCH_W), .HPOS_W(HPOS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_next(input string tag, input int idx);
    logic [11:0] got;
    logic [11:0] exp;
    got = {bus.nsprite, bus.sprdata};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s[%0d] scoreboard empty, observed %h", tag, idx, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s[%0d] observed nsprite/sprdata=%h expected %h", tag, idx, got, exp);
      end
    end
  endtask

  task automatic wr(input int ch, input logic [1:0] r, input logic [15:0] d, input logic [63:0] wd);
    logic [8:0] a;
    a = 9'h140 + 9'(ch * 8) + 9'(r * 2);
    bus.reg_address_in = a[8:1];
    bus.data_in        = d;
    bus.wdata_in       = wd;
    tick();
    bus.reg_address_in = 8'hFF;
  endtask

  // Sweep hpos from h0; one sprite plane pattern with width w starting at hs; pixels equal to 1 show on_val.
  task automatic run_line(input logic [10:0] h0, input int n_en, input int stall_at, input int stall_len,
                          input logic [10:0] hs, input int w, input logic [63:0] pat,
                          input logic [11:0] on_val, input string tag);
    logic [11:0] last;
    logic [11:0] e_val;
    int e;
    int px;
    bit stall;
    last = 12'h0;
    e = 0;
    for (int c = 0; c < n_en + stall_len; c++) begin
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      if (stall) begin
        exp_q.push_back(last);
      end else begin
        px = int'(h0) + e - int'(hs) - 2;
        e_val = 12'h0;
        if (px >= 0 && px < w) begin
          if (pat[w-1-px]) e_val = on_val;
        end
        exp_q.push_back(e_val);
        last = e_val;
        e++;
      end
    end
    e = 0;
    for (int c = 0; c < n_en + stall_len; c++) begin
      stall = (c >= stall_at) && (c < stall_at + stall_len);
      bus.shift_en = !stall;
      bus.hpos     = h0 + 11'(e);
      tick();
      compare_next(tag, c);
      if (!stall) e++;
    end
    bus.shift_en = 1'b1;
    bus.hpos     = H_IDLE;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.shift_en       = 1'b1;
    bus.reg_address_in = 8'hFF;
    bus.data_in        = 16'h0;
    bus.wdata_in       = 64'h0;
    bus.hpos           = H_IDLE;
    bus.spr_width      = 2'b00;
    bus.sprena         = 1'b1;
    repeat (3) tick();
    exp_q.push_back(12'h000);
    compare_next("reset_state", 0);
    reset = 1'b0;
    tick();

    // 16-pixel sprite 0, pixels 0 and 15 set
    wr(0, 2'd0, 16'h0040, 64'h0);
    wr(0, 2'd1, 16'h0000, 64'h0);
    wr(0, 2'd3, 16'h0000, 64'h0);
    wr(0, 2'd2, 16'h0000, 64'h8001);
    run_line(11'h1FC, 24, -1, 0, 11'h200, 16, 64'h8001, {8'h01, 4'h1}, "w16");

    // 64-pixel all-ones sprite 0
    bus.spr_width = 2'b11;
    wr(0, 2'd2, 16'h0000, {64{1'b1}});
    run_line(11'h1FC, 72, -1, 0, 11'h200, 64, {64{1'b1}}, {8'h01, 4'h1}, "w64");

    // CTL write disarms: no reload on the same line
    wr(0, 2'd1, 16'h0000, 64'h0);
    run_line(11'h1FC, 20, -1, 0, 11'h200, 64, 64'h0, 12'h000, "disarm");

    // Attached pair 2/3
    bus.spr_width = 2'b00;
    wr(2, 2'd0, 16'h0050, 64'h0);
    wr(2, 2'd1, 16'h0000, 64'h0);
    wr(2, 2'd3, 16'h0000, 64'h0);
    wr(2, 2'd2, 16'h0000, 64'hFFFF);
    wr(3, 2'd0, 16'h0050, 64'h0);
    wr(3, 2'd1, 16'h0080, 64'h0);
    wr(3, 2'd3, 16'h0000, 64'hFFFF);
    wr(3, 2'd2, 16'h0000, 64'h0);
    run_line(11'h27C, 24, -1, 0, 11'h280, 16, 64'hFFFF, {8'h0C, 4'h9}, "attach");

    // Sprites 1 and 6 overlap: pair 0 wins
    wr(1, 2'd0, 16'h0060, 64'h0);
    wr(1, 2'd1, 16'h0000, 64'h0);
    wr(1, 2'd3, 16'h0000, 64'h0);
    wr(1, 2'd2, 16'h0000, 64'hFFFF);
    wr(6, 2'd0, 16'h0060, 64'h0);
    wr(6, 2'd1, 16'h0000, 64'h0);
    wr(6, 2'd3, 16'h0000, 64'hFFFF);
    wr(6, 2'd2, 16'h0000, 64'hFFFF);
    run_line(11'h2FC, 24, -1, 0, 11'h300, 16, 64'hFFFF, {8'h42, 4'h1}, "prio");
    bus.sprena = 1'b0;
    run_line(11'h2FC, 24, -1, 0, 11'h300, 16, 64'hFFFF, 12'h000, "sprena_off");
    bus.sprena = 1'b1;

    // Finest-resolution start offset on sprite 4
    wr(4, 2'd0, 16'h0070, 64'h0);
    wr(4, 2'd1, 16'h0008, 64'h0);
    wr(4, 2'd3, 16'h0000, 64'h0);
    wr(4, 2'd2, 16'h0000, 64'hFFFF);
    run_line(11'h37C, 26, -1, 0, 11'h381, 16, 64'hFFFF, {8'h10, 4'h9}, "subpix");

    // shift_en low for 3 cycles mid-sprite on sprite 5
    wr(5, 2'd0, 16'h0078, 64'h0);
    wr(5, 2'd1, 16'h0000, 64'h0);
    wr(5, 2'd3, 16'h0000, 64'h0);
    wr(5, 2'd2, 16'h0000, 64'hA5A5);
    run_line(11'h3BC, 24, 10, 3, 11'h3C0, 16, 64'hA5A5, {8'h20, 4'h9}, "stall");

    // Reset mid-sprite on sprite 7, then no redisplay without a new DATA write
    wr(7, 2'd0, 16'h0020, 64'h0);
    wr(7, 2'd1, 16'h0000, 64'h0);
    wr(7, 2'd3, 16'h0000, 64'h0);
    wr(7, 2'd2, 16'h0000, 64'hFFFF);
    run_line(11'h0FC, 12, -1, 0, 11'h100, 16, 64'hFFFF, {8'h80, 4'hD}, "pre_reset");
    reset = 1'b1;
    exp_q.push_back(12'h000);
    tick();
    compare_next("reset_mid", 0);
    reset = 1'b0;
    run_line(11'h0FC, 24, -1, 0, 11'h100, 16, 64'h0, 12'h000, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
